// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state types and defaults for the UART command receiver
package uart_pkg;

    // 50 MHz / 19200 baud
    localparam int BAUD_DIV_DEF = 2604;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    typedef enum logic {
        WAIT_HI = 1'b0,
        WAIT_LO = 1'b1
    } asm_state_e;

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 byte receiver with input synchronizer and mid-bit sampling
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic [7:0] rx_data_o,
    output logic       byte_rdy_o,
    output logic       frm_err_o
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    // The counter expires on zero, so an N-cycle interval loads N-1.
    localparam logic [CNT_W-1:0] FULL_LD = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LD = CNT_W'((BAUD_DIV >> 1) - 1);

    logic             rx_ff1_q, rx_ff2_q, rx_prev_q;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             expire;
    logic             fall;
    logic             byte_rdy, frm_err;

    // Synchronizer and edge-detect flops preset to the idle-high line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ff1_q  <= 1'b1;
            rx_ff2_q  <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_ff1_q  <= rx_i;
            rx_ff2_q  <= rx_ff1_q;
            rx_prev_q <= rx_ff2_q;
        end
    end

    assign expire = (cnt_q == '0);
    assign fall   = rx_prev_q & ~rx_ff2_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        byte_rdy  = 1'b0;
        frm_err   = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (fall) begin
                    cnt_d   = HALF_LD;
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (!expire) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rx_ff2_q) begin
                    state_d = RX_IDLE;
                end else begin
                    cnt_d     = FULL_LD;
                    bit_cnt_d = 3'd0;
                    state_d   = RX_DATA;
                end
            end
            RX_DATA: begin
                if (!expire) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shift_d   = {rx_ff2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    cnt_d     = FULL_LD;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (!expire) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    byte_rdy = rx_ff2_q;
                    frm_err  = ~rx_ff2_q;
                    state_d  = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
        end
    end

    assign rx_data_o  = shift_q;
    assign byte_rdy_o = byte_rdy;
    assign frm_err_o  = frm_err;

endmodule

// File: rtl/uart_cmd_rcv.sv
// rtl/uart_cmd_rcv.sv - pairs received UART bytes into 16-bit commands with a ready/clear handshake
module uart_cmd_rcv
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    input  logic        clr_cmd_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    output logic        frm_err
);

    logic [7:0]  rx_data;
    logic        byte_rdy;
    logic        rx_frm_err;
    asm_state_e  asm_q, asm_d;
    logic [15:0] cmd_q, cmd_d;
    logic        cmd_rdy_q, cmd_rdy_d;

    uart_rx #(
        .BAUD_DIV(BAUD_DIV)
    ) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_i      (RX),
        .rx_data_o (rx_data),
        .byte_rdy_o(byte_rdy),
        .frm_err_o (rx_frm_err)
    );

    // A low-byte capture sets ready even if the consumer clears in the same cycle.
    always_comb begin
        asm_d     = asm_q;
        cmd_d     = cmd_q;
        cmd_rdy_d = clr_cmd_rdy ? 1'b0 : cmd_rdy_q;
        case (asm_q)
            WAIT_HI: begin
                if (byte_rdy) begin
                    cmd_d[15:8] = rx_data;
                    cmd_rdy_d   = 1'b0;
                    asm_d       = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (byte_rdy) begin
                    cmd_d[7:0] = rx_data;
                    cmd_rdy_d  = 1'b1;
                    asm_d      = WAIT_HI;
                end else if (rx_frm_err) begin
                    asm_d = WAIT_HI;
                end
            end
            default: asm_d = WAIT_HI;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q     <= WAIT_HI;
            cmd_q     <= 16'h0000;
            cmd_rdy_q <= 1'b0;
        end else begin
            asm_q     <= asm_d;
            cmd_q     <= cmd_d;
            cmd_rdy_q <= cmd_rdy_d;
        end
    end

    assign cmd     = cmd_q;
    assign cmd_rdy = cmd_rdy_q;
    assign frm_err = rx_frm_err;

endmodule

// File: tb/tb_uart_cmd_rcv.sv
// tb/tb_uart_cmd_rcv.sv - self-checking bench for uart_cmd_rcv with a frame-level reference model
module tb_uart_cmd_rcv;

    localparam int B = 16;
    // Stop-bit sample: 2 synchronizer cycles, half a bit, then nine full bits after the start drive.
    localparam int STOP_OFS = 2 + B / 2 + 9 * B;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RX;
    logic        clr_cmd_rdy;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        frm_err;

    always #5 clk = ~clk;

    uart_cmd_rcv #(.BAUD_DIV(B)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .RX         (RX),
        .clr_cmd_rdy(clr_cmd_rdy),
        .cmd        (cmd),
        .cmd_rdy    (cmd_rdy),
        .frm_err    (frm_err)
    );

    typedef struct {
        int         cyc;
        bit         good;
        logic [7:0] data;
    } ev_t;

    ev_t         evq[$];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          fe_cnt = 0;
    logic [15:0] m_cmd = 16'h0000;
    logic        m_rdy = 1'b0;
    bit          m_lo = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: frames resolve at their stop-sample cycle, then the pairing rules apply.
    always @(negedge clk) begin
        bit         have_ev;
        ev_t        ev;
        have_ev = 1'b0;
        if (frm_err === 1'b1) fe_cnt++;
        if (!rst_n) begin
            evq.delete();
            m_cmd = 16'h0000;
            m_rdy = 1'b0;
            m_lo  = 1'b0;
            chk("rst_cmd", cmd, 16'h0000);
            chk("rst_rdy", {15'd0, cmd_rdy}, 16'd0);
            chk("rst_frm_err", {15'd0, frm_err}, 16'd0);
        end else begin
            if (evq.size() > 0 && evq[0].cyc == cyc) begin
                ev = evq.pop_front();
                have_ev = 1'b1;
            end
            chk("frm_err", {15'd0, frm_err}, {15'd0, have_ev && !ev.good});
            chk("cmd", cmd, m_cmd);
            chk("cmd_rdy", {15'd0, cmd_rdy}, {15'd0, m_rdy});
            if (clr_cmd_rdy) m_rdy = 1'b0;
            if (have_ev && ev.good) begin
                if (!m_lo) begin
                    m_cmd[15:8] = ev.data;
                    m_rdy = 1'b0;
                end else begin
                    m_cmd[7:0] = ev.data;
                    m_rdy = 1'b1;
                end
                m_lo = !m_lo;
            end else if (have_ev) begin
                m_lo = 1'b0;
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit clr_at_stop);
        evq.push_back('{cyc: cyc + STOP_OFS, good: stop_ok, data: d});
        RX = 1'b0;
        wait_cyc(B);
        for (int i = 0; i < 8; i++) begin
            RX = d[i];
            wait_cyc(B);
        end
        RX = stop_ok;
        for (int i = 0; i < B; i++) begin
            clr_cmd_rdy = clr_at_stop && (i == 2 + B / 2);
            wait_cyc(1);
        end
        clr_cmd_rdy = 1'b0;
        RX = 1'b1;
    endtask

    initial begin
        int fe0;
        rst_n = 1'b0;
        RX = 1'b1;
        clr_cmd_rdy = 1'b0;
        wait_cyc(3);
        chk("reset_cmd", cmd, 16'h0000);
        chk("reset_rdy", {15'd0, cmd_rdy}, 16'd0);
        rst_n = 1'b1;
        wait_cyc(5);

        fe0 = fe_cnt;
        send_frame(8'hA5, 1'b1, 1'b0);
        send_frame(8'h5A, 1'b1, 1'b0);
        chk("pair_cmd", cmd, 16'hA55A);
        chk("pair_rdy", {15'd0, cmd_rdy}, 16'd1);
        chk("pair_no_frm_err", 16'(fe_cnt - fe0), 16'd0);

        clr_cmd_rdy = 1'b1;
        wait_cyc(1);
        clr_cmd_rdy = 1'b0;
        chk("clr_rdy", {15'd0, cmd_rdy}, 16'd0);
        chk("clr_cmd_kept", cmd, 16'hA55A);
        wait_cyc(5);

        send_frame(8'h12, 1'b1, 1'b0);
        send_frame(8'h34, 1'b1, 1'b1);
        chk("set_beats_clr_rdy", {15'd0, cmd_rdy}, 16'd1);
        chk("set_beats_clr_cmd", cmd, 16'h1234);
        wait_cyc(5);

        RX = 1'b0;
        wait_cyc(4);
        RX = 1'b1;
        wait_cyc(40);
        chk("false_start_cmd", cmd, 16'h1234);
        send_frame(8'hC3, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0);
        chk("after_false_start", cmd, 16'hC33C);
        wait_cyc(5);

        fe0 = fe_cnt;
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0);
        wait_cyc(20);
        chk("frm_err_pulses", 16'(fe_cnt - fe0), 16'd1);
        chk("frm_err_no_rdy", {15'd0, cmd_rdy}, 16'd0);
        send_frame(8'h33, 1'b1, 1'b0);
        send_frame(8'h44, 1'b1, 1'b0);
        chk("resync_cmd", cmd, 16'h3344);
        chk("resync_rdy", {15'd0, cmd_rdy}, 16'd1);
        wait_cyc(5);

        send_frame(8'h77, 1'b1, 1'b0);
        wait_cyc(5);
        chk("pre_reset_cmd", cmd, 16'h7744);
        fork
            send_frame(8'h88, 1'b1, 1'b0);
            begin
                wait_cyc(70);
                rst_n = 1'b0;
                #1;
                chk("async_rst_cmd", cmd, 16'h0000);
                chk("async_rst_rdy", {15'd0, cmd_rdy}, 16'd0);
            end
        join
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(5);
        send_frame(8'hBE, 1'b1, 1'b0);
        send_frame(8'hEF, 1'b1, 1'b0);
        chk("post_reset_cmd", cmd, 16'hBEEF);
        chk("post_reset_rdy", {15'd0, cmd_rdy}, 16'd1);
        wait_cyc(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
